// File: rtl/tcp_pkg.sv
// Shared definitions for the TCP header parser.
// Holds the parser FSM state encoding, the word positions of the fixed
// TCP header inside the 32-bit segment word stream, and the minimum legal
// data offset (in 32-bit words).
package tcp_pkg;

    // Parser FSM states
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_HDR  = 3'd1,
        ST_OPT  = 3'd2,
        ST_PAY  = 3'd3,
        ST_DROP = 3'd4
    } tcp_state_t;

    // Word indices of the fixed 20-byte header
    localparam logic [3:0] W_PORTS = 4'd0;
    localparam logic [3:0] W_SEQ   = 4'd1;
    localparam logic [3:0] W_ACK   = 4'd2;
    localparam logic [3:0] W_CTRL  = 4'd3;
    localparam logic [3:0] W_CSUM  = 4'd4;

    // First option word follows the fixed header
    localparam logic [3:0] W_OPT_FIRST = 4'd5;

    // Smallest data offset that still covers the fixed header
    localparam logic [3:0] MIN_DATA_OFF = 4'd5;

    // Word counter saturation value
    localparam logic [3:0] WCNT_MAX = 4'd15;

endpackage

// File: rtl/tcp_header_parser.sv
// tcp_header_parser
// Splits a big-endian 32-bit TCP segment word stream into header fields,
// an option word stream and a payload word stream. No backpressure: every
// cycle with in_valid=1 consumes one word.
//
// Ports
//   clk, reset        : clock, asynchronous active-low reset
//   in_data/valid/sop/eop : segment word stream, header word 0 at in_sop
//   src_port .. urg_ptr   : captured header fields, held until overwritten
//   hdr_valid         : one-cycle pulse once the fixed header is complete
//   opt_*             : option words, 1-cycle latency, sop/eop framed
//   pay_*             : payload words, 1-cycle latency
//   hdr_err           : pulse when data_off < 5
//   trunc_err         : pulse when a segment ends or restarts too early
module tcp_header_parser
    import tcp_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] in_data,
    input  logic        in_valid,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [31:0] seq_num,
    output logic [31:0] ack_num,
    output logic [3:0]  data_off,
    output logic [8:0]  flags,
    output logic [15:0] window,
    output logic [15:0] checksum,
    output logic [15:0] urg_ptr,
    output logic        hdr_valid,
    output logic [31:0] opt_data,
    output logic        opt_valid,
    output logic        opt_sop,
    output logic        opt_eop,
    output logic [31:0] pay_data,
    output logic        pay_valid,
    output logic        pay_eop,
    output logic        hdr_err,
    output logic        trunc_err
);

    tcp_state_t state, state_next;
    logic [3:0] wcnt, wcnt_next, wcnt_inc;
    logic       ld_ports, ld_seq, ld_ack, ld_ctrl, ld_csum;
    logic       hdr_valid_n, hdr_err_n, trunc_err_n;
    logic       opt_valid_n, opt_sop_n, opt_eop_n;
    logic       pay_valid_n, pay_eop_n;
    logic       opt_last;

    assign wcnt_inc = (wcnt == WCNT_MAX) ? WCNT_MAX : wcnt + 4'd1;
    // The option area ends on word data_off-1; data_off is already
    // registered by the time any option word arrives.
    assign opt_last = (wcnt == data_off - 4'd1);

    // Next-state and next-output decode. A start-of-segment word always
    // wins and restarts header capture; everything else depends on state.
    always_comb begin
        state_next  = state;
        wcnt_next   = wcnt;
        ld_ports    = 1'b0;
        ld_seq      = 1'b0;
        ld_ack      = 1'b0;
        ld_ctrl     = 1'b0;
        ld_csum     = 1'b0;
        hdr_valid_n = 1'b0;
        hdr_err_n   = 1'b0;
        trunc_err_n = 1'b0;
        opt_valid_n = 1'b0;
        opt_sop_n   = 1'b0;
        opt_eop_n   = 1'b0;
        pay_valid_n = 1'b0;
        pay_eop_n   = 1'b0;

        if (in_valid) begin
            if (in_sop) begin
                ld_ports    = 1'b1;
                trunc_err_n = (state != ST_IDLE) && (state != ST_DROP);
                if (in_eop) begin
                    trunc_err_n = 1'b1;
                    state_next  = ST_IDLE;
                end else begin
                    state_next = ST_HDR;
                    wcnt_next  = W_SEQ;
                end
            end else begin
                case (state)
                    ST_HDR: begin
                        wcnt_next = wcnt_inc;
                        ld_seq    = (wcnt == W_SEQ);
                        ld_ack    = (wcnt == W_ACK);
                        if (wcnt == W_CTRL) begin
                            ld_ctrl = 1'b1;
                            if (in_data[31:28] < MIN_DATA_OFF) begin
                                hdr_err_n  = 1'b1;
                                state_next = in_eop ? ST_IDLE : ST_DROP;
                            end else if (in_eop) begin
                                trunc_err_n = 1'b1;
                                state_next  = ST_IDLE;
                            end
                        end else if (wcnt == W_CSUM) begin
                            ld_csum     = 1'b1;
                            hdr_valid_n = 1'b1;
                            if (in_eop) begin
                                // Header is whole, but promised options are missing
                                trunc_err_n = (data_off > MIN_DATA_OFF);
                                state_next  = ST_IDLE;
                            end else begin
                                state_next = (data_off > MIN_DATA_OFF) ? ST_OPT : ST_PAY;
                            end
                        end else if (in_eop) begin
                            trunc_err_n = 1'b1;
                            state_next  = ST_IDLE;
                        end
                    end
                    ST_OPT: begin
                        wcnt_next   = wcnt_inc;
                        opt_valid_n = 1'b1;
                        opt_sop_n   = (wcnt == W_OPT_FIRST);
                        if (opt_last) begin
                            opt_eop_n  = 1'b1;
                            state_next = in_eop ? ST_IDLE : ST_PAY;
                        end else if (in_eop) begin
                            trunc_err_n = 1'b1;
                            state_next  = ST_IDLE;
                        end
                    end
                    ST_PAY: begin
                        pay_valid_n = 1'b1;
                        pay_eop_n   = in_eop;
                        if (in_eop) begin
                            state_next = ST_IDLE;
                        end
                    end
                    ST_DROP: begin
                        if (in_eop) begin
                            state_next = ST_IDLE;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if (state_next == ST_IDLE) begin
            wcnt_next = W_PORTS;
        end
    end

    // State, counter and all registered outputs. Header fields only load
    // on their own word so they hold between segments.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            wcnt      <= W_PORTS;
            src_port  <= '0;
            dst_port  <= '0;
            seq_num   <= '0;
            ack_num   <= '0;
            data_off  <= '0;
            flags     <= '0;
            window    <= '0;
            checksum  <= '0;
            urg_ptr   <= '0;
            hdr_valid <= 1'b0;
            opt_data  <= '0;
            opt_valid <= 1'b0;
            opt_sop   <= 1'b0;
            opt_eop   <= 1'b0;
            pay_data  <= '0;
            pay_valid <= 1'b0;
            pay_eop   <= 1'b0;
            hdr_err   <= 1'b0;
            trunc_err <= 1'b0;
        end else begin
            state     <= state_next;
            wcnt      <= wcnt_next;
            hdr_valid <= hdr_valid_n;
            hdr_err   <= hdr_err_n;
            trunc_err <= trunc_err_n;
            opt_valid <= opt_valid_n;
            opt_sop   <= opt_sop_n;
            opt_eop   <= opt_eop_n;
            pay_valid <= pay_valid_n;
            pay_eop   <= pay_eop_n;
            if (ld_ports) begin
                src_port <= in_data[31:16];
                dst_port <= in_data[15:0];
            end
            if (ld_seq) begin
                seq_num <= in_data;
            end
            if (ld_ack) begin
                ack_num <= in_data;
            end
            if (ld_ctrl) begin
                data_off <= in_data[31:28];
                flags    <= in_data[24:16];
                window   <= in_data[15:0];
            end
            if (ld_csum) begin
                checksum <= in_data[31:16];
                urg_ptr  <= in_data[15:0];
            end
            if (opt_valid_n) begin
                opt_data <= in_data;
            end
            if (pay_valid_n) begin
                pay_data <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_tcp_header_parser.sv
// Self-checking bench for tcp_header_parser.
// Directed segments are driven on the falling edge; every word that should
// produce an output pushes its expected pulse pattern, data, header snapshot
// and arrival cycle onto a scoreboard queue, and a monitor pops and checks
// whenever the DUT raises any valid/pulse output.
`timescale 1ns/1ps
module tb_tcp_header_parser;

    localparam logic [7:0] F_HDR   = 8'h80;
    localparam logic [7:0] F_HERR  = 8'h40;
    localparam logic [7:0] F_TRUNC = 8'h20;
    localparam logic [7:0] F_OV    = 8'h10;
    localparam logic [7:0] F_OSOP  = 8'h08;
    localparam logic [7:0] F_OEOP  = 8'h04;
    localparam logic [7:0] F_PV    = 8'h02;
    localparam logic [7:0] F_PEOP  = 8'h01;

    typedef struct {
        int           cyc;
        logic [7:0]   flags;
        logic [31:0]  data;
        logic [156:0] hdr;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] in_data;
    logic        in_valid, in_sop, in_eop;
    logic [15:0] src_port, dst_port, window, checksum, urg_ptr;
    logic [31:0] seq_num, ack_num, opt_data, pay_data;
    logic [3:0]  data_off;
    logic [8:0]  tcp_flags;
    logic        hdr_valid, opt_valid, opt_sop, opt_eop;
    logic        pay_valid, pay_eop, hdr_err, trunc_err;

    logic [7:0]   obs_flags;
    logic [156:0] obs_hdr;
    logic [156:0] exp_hdr;
    logic [31:0]  obs_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    always #5 clk = ~clk;

    tcp_header_parser dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .src_port  (src_port),
        .dst_port  (dst_port),
        .seq_num   (seq_num),
        .ack_num   (ack_num),
        .data_off  (data_off),
        .flags     (tcp_flags),
        .window    (window),
        .checksum  (checksum),
        .urg_ptr   (urg_ptr),
        .hdr_valid (hdr_valid),
        .opt_data  (opt_data),
        .opt_valid (opt_valid),
        .opt_sop   (opt_sop),
        .opt_eop   (opt_eop),
        .pay_data  (pay_data),
        .pay_valid (pay_valid),
        .pay_eop   (pay_eop),
        .hdr_err   (hdr_err),
        .trunc_err (trunc_err)
    );

    assign obs_flags = {hdr_valid, hdr_err, trunc_err, opt_valid, opt_sop, opt_eop, pay_valid, pay_eop};
    assign obs_hdr   = {src_port, dst_port, seq_num, ack_num, data_off, tcp_flags, window, checksum, urg_ptr};
    assign obs_data  = opt_valid ? opt_data : pay_data;

    // Monitor: any output activity must match the next scoreboard entry,
    // including the cycle it was due in.
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (reset && obs_flags != 8'h00) begin
            tests++;
            assert (sb.size() > 0) else begin
                fails++;
                $error("[TB] FAIL unexpected_out observed=%h expected=none cyc=%0d", obs_flags, cyc);
            end
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                tests++;
                assert (cyc === mon_e.cyc) else begin
                    fails++;
                    $error("[TB] FAIL out_cycle observed=%0d expected=%0d", cyc, mon_e.cyc);
                end
                tests++;
                assert (obs_flags === mon_e.flags) else begin
                    fails++;
                    $error("[TB] FAIL out_flags observed=%h expected=%h cyc=%0d", obs_flags, mon_e.flags, cyc);
                end
                if ((mon_e.flags & (F_OV | F_PV)) != 8'h00) begin
                    tests++;
                    assert (obs_data === mon_e.data) else begin
                        fails++;
                        $error("[TB] FAIL out_data observed=%h expected=%h cyc=%0d", obs_data, mon_e.data, cyc);
                    end
                end
                if (mon_e.flags[7]) begin
                    tests++;
                    assert (obs_hdr === mon_e.hdr) else begin
                        fails++;
                        $error("[TB] FAIL hdr_fields observed=%h expected=%h cyc=%0d", obs_hdr, mon_e.hdr, cyc);
                    end
                end
            end
        end
    end

    // Drive one word; a nonzero expected pattern is queued for the next edge.
    task automatic apply_stimulus(input logic [31:0] d, input logic sop, input logic eop,
                                  input logic [7:0] ef);
        exp_t e;
        @(negedge clk);
        in_data  = d;
        in_sop   = sop;
        in_eop   = eop;
        in_valid = 1'b1;
        if (ef != 8'h00) begin
            e.cyc   = cyc + 1;
            e.flags = ef;
            e.data  = d;
            e.hdr   = exp_hdr;
            sb.push_back(e);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sop   = 1'b0;
            in_eop   = 1'b0;
            in_data  = 32'h0;
        end
    endtask

    // Every output should read zero (reset / post-reset quiet checks).
    task automatic check_output(input string tag);
        tests++;
        assert (obs_flags === 8'h00) else begin
            fails++;
            $error("[TB] FAIL %s_pulses observed=%h expected=00", tag, obs_flags);
        end
        tests++;
        assert (obs_hdr === 157'h0) else begin
            fails++;
            $error("[TB] FAIL %s_fields observed=%h expected=0", tag, obs_hdr);
        end
        tests++;
        assert ({opt_data, pay_data} === 64'h0) else begin
            fails++;
            $error("[TB] FAIL %s_data observed=%h expected=0", tag, {opt_data, pay_data});
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset    = 1'b0;
        in_data  = 32'h0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        exp_hdr  = '0;
        repeat (3) @(negedge clk);
        check_output("reset");
        @(negedge clk);
        reset = 1'b1;
        idle_cycles(2);

        // doff=5, two payload words, with an idle gap inside the header
        exp_hdr = {16'h1234, 16'h0050, 32'hA1B2C3D4, 32'h0BADF00D, 4'h5, 9'h018, 16'hFFFF, 16'hBEEF, 16'h0000};
        apply_stimulus(32'h12340050, 1'b1, 1'b0, 8'h00);
        apply_stimulus(32'hA1B2C3D4, 1'b0, 1'b0, 8'h00);
        idle_cycles(1);
        apply_stimulus(32'h0BADF00D, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h5018FFFF, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'hBEEF0000, 1'b0, 1'b0, F_HDR);
        apply_stimulus(32'hDEADBEEF, 1'b0, 1'b0, F_PV);
        apply_stimulus(32'hCAFEF00D, 1'b0, 1'b1, F_PV | F_PEOP);
        idle_cycles(3);
        tests++;
        assert (obs_hdr === exp_hdr) else begin
            fails++;
            $error("[TB] FAIL hdr_hold observed=%h expected=%h", obs_hdr, exp_hdr);
        end

        // doff=8 with three option words, then one payload word
        exp_hdr = {16'hC001, 16'h0016, 32'h00000001, 32'h00000000, 4'h8, 9'h002, 16'h7210, 16'h1A2B, 16'h0000};
        apply_stimulus(32'hC0010016, 1'b1, 1'b0, 8'h00);
        apply_stimulus(32'h00000001, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h00000000, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h80027210, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h1A2B0000, 1'b0, 1'b0, F_HDR);
        apply_stimulus(32'h020405B4, 1'b0, 1'b0, F_OV | F_OSOP);
        apply_stimulus(32'h01030307, 1'b0, 1'b0, F_OV);
        apply_stimulus(32'h01010402, 1'b0, 1'b0, F_OV | F_OEOP);
        apply_stimulus(32'h11223344, 1'b0, 1'b1, F_PV | F_PEOP);
        idle_cycles(2);

        // data_off=4: header error, drop, restart in DROP without trunc_err,
        // then a header-only segment ending on word 4
        apply_stimulus(32'h00010002, 1'b1, 1'b0, 8'h00);
        apply_stimulus(32'h00000010, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h00000020, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h40100100, 1'b0, 1'b0, F_HERR);
        apply_stimulus(32'h55555555, 1'b0, 1'b0, 8'h00);
        exp_hdr = {16'hABCD, 16'h0443, 32'h13572468, 32'h24681357, 4'h5, 9'h011, 16'h0200, 16'h0F0F, 16'h0000};
        apply_stimulus(32'hABCD0443, 1'b1, 1'b0, 8'h00);
        apply_stimulus(32'h13572468, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h24681357, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h50110200, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h0F0F0000, 1'b0, 1'b1, F_HDR);
        apply_stimulus(32'h77777777, 1'b0, 1'b0, 8'h00);
        idle_cycles(2);

        // doff=10, segment ends on the second option word
        exp_hdr = {16'h2222, 16'h3333, 32'h44445555, 32'h66667777, 4'hA, 9'h010, 16'h0400, 16'h9999, 16'h0000};
        apply_stimulus(32'h22223333, 1'b1, 1'b0, 8'h00);
        apply_stimulus(32'h44445555, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h66667777, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'hA0100400, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h99990000, 1'b0, 1'b0, F_HDR);
        apply_stimulus(32'h01010101, 1'b0, 1'b0, F_OV | F_OSOP);
        apply_stimulus(32'h080A0000, 1'b0, 1'b1, F_OV | F_TRUNC);
        apply_stimulus(32'h88888888, 1'b0, 1'b0, 8'h00);
        idle_cycles(2);

        // Restart inside payload, then reset in the middle of a header
        exp_hdr = {16'h0A0B, 16'h0C0D, 32'h00000100, 32'h00000200, 4'h5, 9'h010, 16'h1000, 16'h1212, 16'h0000};
        apply_stimulus(32'h0A0B0C0D, 1'b1, 1'b0, 8'h00);
        apply_stimulus(32'h00000100, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h00000200, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h50101000, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h12120000, 1'b0, 1'b0, F_HDR);
        apply_stimulus(32'hAAAA0001, 1'b0, 1'b0, F_PV);
        apply_stimulus(32'h0B0B0C0C, 1'b1, 1'b0, F_TRUNC);
        exp_hdr = {16'h0B0B, 16'h0C0C, 32'h00000300, 32'h00000400, 4'h5, 9'h018, 16'h2000, 16'h3434, 16'h0001};
        apply_stimulus(32'h00000300, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h00000400, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h50182000, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h34340001, 1'b0, 1'b0, F_HDR);
        apply_stimulus(32'hBBBB0001, 1'b0, 1'b1, F_PV | F_PEOP);
        apply_stimulus(32'h0C0C0D0D, 1'b1, 1'b0, 8'h00);
        apply_stimulus(32'h00000500, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        #1;
        check_output("mid_reset");
        idle_cycles(2);
        reset = 1'b1;
        apply_stimulus(32'hEEEE0001, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'hEEEE0002, 1'b0, 1'b0, 8'h00);
        idle_cycles(1);
        #1;
        check_output("post_reset");
        exp_hdr = {16'h0D0D, 16'h0E0E, 32'h00000600, 32'h00000700, 4'h5, 9'h002, 16'h3000, 16'h5656, 16'h0000};
        apply_stimulus(32'h0D0D0E0E, 1'b1, 1'b0, 8'h00);
        apply_stimulus(32'h00000600, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h00000700, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h50023000, 1'b0, 1'b0, 8'h00);
        apply_stimulus(32'h56560000, 1'b0, 1'b0, F_HDR);
        apply_stimulus(32'hDDDD0001, 1'b0, 1'b1, F_PV | F_PEOP);
        idle_cycles(4);

        tests++;
        assert (sb.size() === 0) else begin
            fails++;
            $error("[TB] FAIL missing_out observed=%0d expected=0 pending", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
